// File: rtl/multicycle_control.sv
// Multicycle control unit: steps each instruction through FETCH/DECODE/EXEC
// (and WB for loads), keeps the architectural {zero,sign,carry,ovf} flags,
// resolves conditional branches on those latched flags and runs a req/ack
// handshake with data memory. A handshake that waits too long halts with error.
module multicycle_control #(
  parameter int MCODEBITS    = 4,
  parameter int OPW          = 4,
  parameter int MEM_TIMEOUT  = 15,
  parameter int FLAGS_ON_ALU = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic [MCODEBITS-1:0] instr,
  input  logic [1:0]           target_sel,
  input  logic                 alu_zero,
  input  logic                 alu_sign,
  input  logic                 alu_carry,
  input  logic                 alu_ovf,
  input  logic                 mem_ack,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic                 branch_taken,
  output logic [1:0]           jump_sel,
  output logic [OPW-1:0]       alu_op,
  output logic                 alu_src,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic [3:0]           flags,
  output logic                 done,
  output logic                 err
);

  // Control states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Opcodes
  localparam logic [MCODEBITS-1:0] OP_ADD   = MCODEBITS'(4'b0000);
  localparam logic [MCODEBITS-1:0] OP_SUB   = MCODEBITS'(4'b0001);
  localparam logic [MCODEBITS-1:0] OP_AND   = MCODEBITS'(4'b0010);
  localparam logic [MCODEBITS-1:0] OP_OR    = MCODEBITS'(4'b0011);
  localparam logic [MCODEBITS-1:0] OP_XOR   = MCODEBITS'(4'b0100);
  localparam logic [MCODEBITS-1:0] OP_NOT   = MCODEBITS'(4'b0101);
  localparam logic [MCODEBITS-1:0] OP_LOADI = MCODEBITS'(4'b0110);
  localparam logic [MCODEBITS-1:0] OP_ALU7  = MCODEBITS'(4'b0111);
  localparam logic [MCODEBITS-1:0] OP_LOAD  = MCODEBITS'(4'b1000);
  localparam logic [MCODEBITS-1:0] OP_CMP   = MCODEBITS'(4'b1001);
  localparam logic [MCODEBITS-1:0] OP_ALUA  = MCODEBITS'(4'b1010);
  localparam logic [MCODEBITS-1:0] OP_JE    = MCODEBITS'(4'b1011);
  localparam logic [MCODEBITS-1:0] OP_JGE   = MCODEBITS'(4'b1100);
  localparam logic [MCODEBITS-1:0] OP_JLE   = MCODEBITS'(4'b1101);
  localparam logic [MCODEBITS-1:0] OP_ALUE  = MCODEBITS'(4'b1110);
  localparam logic [MCODEBITS-1:0] OP_STORE = MCODEBITS'(4'b1111);

  // ALU operation codes
  localparam logic [OPW-1:0] ALU_PASS = OPW'(4'b1110);
  localparam logic [OPW-1:0] ALU_CMP  = OPW'(4'b0111);

  // Timeout counter wide enough for MEM_TIMEOUT up to 255
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  logic [2:0]           state_q,  state_d;
  logic [MCODEBITS-1:0] opcode_q, opcode_d;
  logic [1:0]           jsel_q,   jsel_d;
  logic [3:0]           flags_q,  flags_d;
  logic                 err_q,    err_d;
  logic [7:0]           cnt_q,    cnt_d;

  // Decoded view of the latched opcode
  logic           is_alu;
  logic           is_cmp;
  logic           is_branch;
  logic           is_load;
  logic           is_store;
  logic           is_mem;
  logic [OPW-1:0] alu_code;
  logic           cond_true;

  logic f_zero;
  logic f_sign;
  logic f_ovf;

  assign f_zero = flags_q[3];
  assign f_sign = flags_q[2];
  assign f_ovf  = flags_q[0];

  // Classify the latched opcode and map ALU opcodes to ALU operation codes
  always_comb begin
    is_alu    = 1'b0;
    is_cmp    = 1'b0;
    is_branch = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    alu_code  = ALU_PASS;
    case (opcode_q)
      OP_ADD:   begin is_alu = 1'b1; alu_code = OPW'(4'b0000); end
      OP_SUB:   begin is_alu = 1'b1; alu_code = OPW'(4'b0001); end
      OP_AND:   begin is_alu = 1'b1; alu_code = OPW'(4'b0010); end
      OP_OR:    begin is_alu = 1'b1; alu_code = OPW'(4'b0011); end
      OP_XOR:   begin is_alu = 1'b1; alu_code = OPW'(4'b0100); end
      OP_NOT:   begin is_alu = 1'b1; alu_code = OPW'(4'b0101); end
      OP_ALU7:  begin is_alu = 1'b1; alu_code = OPW'(4'b0110); end
      OP_ALUA:  begin is_alu = 1'b1; alu_code = OPW'(4'b1000); end
      OP_ALUE:  begin is_alu = 1'b1; alu_code = OPW'(4'b1001); end
      OP_CMP:   begin is_cmp = 1'b1; alu_code = ALU_CMP; end
      OP_JE,
      OP_JGE,
      OP_JLE:   is_branch = 1'b1;
      OP_LOAD,
      OP_LOADI: is_load = 1'b1;
      OP_STORE: is_store = 1'b1;
      default:  ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Branch condition against the architectural (latched) flags only
  always_comb begin
    cond_true = 1'b0;
    case (opcode_q)
      OP_JE:   cond_true = f_zero;
      OP_JGE:  cond_true = (f_sign == f_ovf);
      OP_JLE:  cond_true = f_zero | (f_sign ^ f_ovf);
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state logic: sequencing, opcode latch, flag writes and timeout tracking
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    jsel_d   = jsel_q;
    flags_d  = flags_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opcode_d = instr;
        jsel_d   = target_sel;
        cnt_d    = 8'd0;
        state_d  = halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (is_mem) begin
          // Ack wins even on the cycle the count reaches the limit
          if (mem_ack) begin
            state_d = is_load ? S_WB : S_FETCH;
          end else if (cnt_q == TIMEOUT_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = S_FETCH;
          if (is_cmp || ((FLAGS_ON_ALU != 0) && is_alu)) begin
            flags_d = {alu_zero, alu_sign, alu_carry, alu_ovf};
          end
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      jsel_q   <= 2'b00;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      jsel_q   <= jsel_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode from registered state and latched opcode; only the store
  // completion strobe looks at mem_ack combinationally
  always_comb begin
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    branch_taken = 1'b0;
    alu_op       = ALU_PASS;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    case (state_q)
      S_IDLE: begin
        alu_op = '0;
      end
      S_FETCH: begin
        ir_load = 1'b1;
      end
      S_EXEC: begin
        alu_op = alu_code;
        if (is_alu) begin
          reg_write = 1'b1;
          pc_en     = 1'b1;
        end else if (is_cmp) begin
          pc_en = 1'b1;
        end else if (is_branch) begin
          pc_en        = 1'b1;
          branch_taken = cond_true;
        end else if (is_mem) begin
          alu_src   = 1'b1;
          mem_req   = 1'b1;
          mem_write = is_store;
          pc_en     = is_store & mem_ack;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        pc_en      = 1'b1;
      end
      default: ;
    endcase
  end

  assign jump_sel = jsel_q;
  assign flags    = flags_q;
  assign done     = (state_q == S_HALT);
  assign err      = err_q;

endmodule
